uart_rx: RTL
============

Name: uart_rx

Overview:
8N1 UART receiver that consumes the serial line driven by the team's Transmitter block and recovers parallel bytes.
- Synchronises the asynchronous line, validates the start bit at mid-bit, and samples 8 data bits LSB-first plus one stop bit.
- Presents each byte with a one-cycle valid strobe, or flags a framing error.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); legal range >= 4.
Derived HALF_BIT = CLKS_PER_BIT/2 (integer division).
Derived counter width = $clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
rx_serial  input  1  asynchronous serial line; idle = 1
rx_data  output  8  last correctly received byte
rx_valid  output  1  one-cycle pulse: rx_data was just updated
frame_error  output  1  one-cycle pulse: stop bit sampled as 0
rx_busy  output  1  high in every state except IDLE

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset=0), all asynchronous:
  - rx_data=8'h00, rx_valid=0, frame_error=0, rx_busy=0.
  - Both synchroniser flops =1; shift register =0; counters =0; state=IDLE.
- Synchroniser: two flops on rx_serial; the FSM sees only rx_sync (2-cycle delay). No other logic uses rx_serial directly.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rx_sync==0, go to START and clear the bit counter. Call this cycle t0.
- START: count to HALF_BIT-1, then sample.
  - rx_sync==0: clear counter, go to DATA.
  - rx_sync==1 (glitch): go to IDLE; no strobe.
- DATA: count to CLKS_PER_BIT-1, then sample.
  - Shift into bit[index], LSB first; index runs 0..7.
  - After index 7, go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample.
  - rx_sync==1: rx_data<=shift register, rx_valid=1 for the next cycle only, go to IDLE.
  - rx_sync==0: frame_error=1 for the next cycle only, rx_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_sync==1, then go to IDLE. Break conditions therefore never retrigger reception.
- Sample timing: sample k is taken at cycle t0 + HALF_BIT + k*CLKS_PER_BIT (+/-1 permitted).
  - k=0 is the start bit, k=1..8 are data bits, k=9 is the stop bit.
  - rx_valid / frame_error assert the cycle after sample 9.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets a start bit immediately following the stop bit be detected with no lost frame.
- rx_valid and frame_error are mutually exclusive and never asserted for more than 1 cycle.
- rx_data holds its value between frames; it changes only on valid completion or reset.
- Reset mid-frame aborts immediately. After release the FSM is in IDLE and the partial frame is discarded.
- The counter never wraps: it is cleared on every sample and on every state change.

Test Plan:
1. CLKS_PER_BIT=16, send 0x55 (start, 1010_1010 LSB-first, stop) -> rx_valid high exactly 1 cycle, rx_data=0x55, frame_error stays 0, rx_busy falls by mid-stop-bit.
2. Back-to-back 0xA3 then 0x3C, no idle gap -> two rx_valid pulses about 160 cycles apart, rx_data=0xA3 then 0x3C.
3. rx_serial low for 4 cycles then high -> FSM returns to IDLE after the start check, no rx_valid/frame_error, rx_data keeps its previous value. Then send 0x0F -> received correctly.
4. Send 0xF0 with stop bit forced 0, then hold the line low for 40 cycles -> frame_error pulses once, rx_data unchanged, rx_busy stays 1 until the line returns high. A following 0x81 is received.
5. Assert reset during data bit 4 of 0xC7 -> outputs go to 0 immediately (rx_data=0x00). After release, send 0x5A -> rx_data=0x5A with a single rx_valid.
6. Default CLKS_PER_BIT=5208, send 0xFF and 0x00 -> both received correctly; sample instants land within +/-1 cycle of mid-bit.

Source files
------------

// File: rtl/uart_rx_if.sv
// Signal bundle between a serial line driver and the uart_rx receiver.
// rx_valid/frame_error are one-cycle strobes with no ready: the consumer must take rx_data in that cycle.
interface uart_rx_if;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       rx_busy;
    logic [2:0] dbg_state;

    modport master (
        output rx_serial,
        input  rx_data, rx_valid, frame_error, rx_busy, dbg_state
    );

    modport slave (
        input  rx_serial,
        output rx_data, rx_valid, frame_error, rx_busy, dbg_state
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, byte strobe or framing-error strobe.
// The FSM state is exported on bus.dbg_state for checkers.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic             r_sync1;
    logic             r_sync2;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ferr;

    logic w_rx_sync;
    logic w_half_done;
    logic w_bit_done;

    assign w_rx_sync   = r_sync2;
    assign w_half_done = (r_cnt == HALF_LAST);
    assign w_bit_done  = (r_cnt == FULL_LAST);

    // Synchroniser resets to the idle line level so release never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_sync) begin
                        r_idx   <= 3'd0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_half_done) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx_sync;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop-bit leaves half a bit to catch an immediately following start.
                    if (w_bit_done) begin
                        r_cnt <= '0;
                        if (w_rx_sync) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    r_cnt <= '0;
                    if (w_rx_sync) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_data     = r_data;
    assign bus.rx_valid    = r_valid;
    assign bus.frame_error = r_ferr;
    assign bus.rx_busy     = (r_state != S_IDLE);
    assign bus.dbg_state   = r_state;
endmodule
